// File: rtl/apb_slave_pkg.sv
// Shared types and constants for the APB register-bank responder.
package apb_slave_pkg;

  typedef enum logic {
    IDLE   = 1'b0,
    ACCESS = 1'b1
  } state_e;

  localparam logic [31:0] ID_VALUE_DEFAULT = 32'hA5B0_0001;
  localparam int          CNT_W            = 4;

  // One index bit beyond $clog2 so an address just past the bank is seen as out of range.
  function automatic int idx_width(input int num_regs);
    return $clog2(num_regs) + 1;
  endfunction

endpackage

// File: rtl/apb_slave_regbank_if.sv
// APB bus bundle between the bridge's APB master and one responder.
interface apb_slave_regbank_if;
  logic        Psel;
  logic        Penable;
  logic        Pwrite;
  logic [31:0] Paddr;
  logic [31:0] Pwdata;
  logic [31:0] Prdata;
  logic        Pready;
  logic        Pslverr;

  modport master (
    output Psel, Penable, Pwrite, Paddr, Pwdata,
    input  Prdata, Pready, Pslverr
  );

  modport slave (
    input  Psel, Penable, Pwrite, Paddr, Pwdata,
    output Prdata, Pready, Pslverr
  );
endinterface

// File: rtl/apb_wait_counter.sv
// Down-counter that sets the number of Pready-low cycles in an access phase.
module apb_wait_counter #(
  parameter int CNT_W = 4
) (
  input  logic             Hclk,
  input  logic             Hresetn,
  input  logic             load_i,
  input  logic [CNT_W-1:0] load_val_i,
  input  logic             dec_i,
  output logic             zero_o
);

  logic [CNT_W-1:0] cnt_q, cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    if (load_i)                   cnt_d = load_val_i;
    else if (dec_i && cnt_q != 0) cnt_d = cnt_q - 1'b1;
  end

  always_ff @(posedge Hclk or negedge Hresetn) begin
    if (!Hresetn) cnt_q <= '0;
    else          cnt_q <= cnt_d;
  end

  assign zero_o = (cnt_q == '0);

endmodule

// File: rtl/apb_slave_regbank.sv
// APB responder serving a small register bank with fixed wait states and error reporting.
module apb_slave_regbank
  import apb_slave_pkg::*;
#(
  parameter int          NUM_REGS    = 8,
  parameter int          WAIT_STATES = 2,
  parameter logic [31:0] ID_VALUE    = ID_VALUE_DEFAULT
) (
  input  logic               Hclk,
  input  logic               Hresetn,
  apb_slave_regbank_if.slave apb
);

  localparam int IDX_W  = idx_width(NUM_REGS);
  localparam int ADDR_W = IDX_W + 2;

  state_e            state_q, state_d;
  logic [ADDR_W-1:0] addr_q;
  logic              write_q;
  logic [31:0]       wdata_q;
  logic [31:0]       regs_q [1:NUM_REGS-1];

  logic [IDX_W-1:0]  idx;
  logic              err;
  logic              load, dec, cnt_zero, capture, commit;
  logic [31:0]       rdata;
  logic              unused_paddr;

  // Upper address bits were already decoded by the bridge into Pselx.
  assign unused_paddr = ^apb.Paddr[31:ADDR_W];

  assign idx = addr_q[ADDR_W-1:2];
  assign err = (addr_q[1:0] != 2'b00) || (32'(idx) >= NUM_REGS) ||
               (write_q && idx == '0);

  apb_wait_counter #(.CNT_W(CNT_W)) u_wait (
    .Hclk       (Hclk),
    .Hresetn    (Hresetn),
    .load_i     (load),
    .load_val_i (CNT_W'(WAIT_STATES)),
    .dec_i      (dec),
    .zero_o     (cnt_zero)
  );

  always_comb begin
    state_d = state_q;
    load    = 1'b0;
    dec     = 1'b0;
    capture = 1'b0;
    commit  = 1'b0;
    case (state_q)
      IDLE: begin
        if (apb.Psel && !apb.Penable) begin
          capture = 1'b1;
          load    = 1'b1;
          state_d = ACCESS;
        end
      end
      ACCESS: begin
        if (!apb.Psel) begin
          state_d = IDLE;
        end else if (!apb.Penable) begin
          // A fresh setup mid-access replaces the transfer in flight.
          capture = 1'b1;
          load    = 1'b1;
        end else if (!cnt_zero) begin
          dec = 1'b1;
        end else begin
          commit  = write_q && !err;
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge Hclk or negedge Hresetn) begin
    if (!Hresetn) state_q <= IDLE;
    else          state_q <= state_d;
  end

  always_ff @(posedge Hclk) begin
    if (capture) begin
      addr_q  <= apb.Paddr[ADDR_W-1:0];
      write_q <= apb.Pwrite;
      wdata_q <= apb.Pwdata;
    end
  end

  always_ff @(posedge Hclk or negedge Hresetn) begin
    if (!Hresetn) begin
      for (int i = 1; i < NUM_REGS; i++) regs_q[i] <= '0;
    end else begin
      for (int i = 1; i < NUM_REGS; i++)
        if (commit && idx == IDX_W'(i)) regs_q[i] <= wdata_q;
    end
  end

  always_comb begin
    rdata = '0;
    if (idx == '0) rdata = ID_VALUE;
    for (int i = 1; i < NUM_REGS; i++)
      if (idx == IDX_W'(i)) rdata = regs_q[i];
  end

  assign apb.Pready  = (state_q == ACCESS) && apb.Psel && apb.Penable && cnt_zero;
  assign apb.Pslverr = apb.Pready && err;
  assign apb.Prdata  = (apb.Pready && !write_q && !err) ? rdata : '0;

endmodule

// File: tb/tb_apb_slave_regbank.sv
// Directed bench: one bank with two wait states, one with none, sharing clock and reset.
module tb_apb_slave_regbank;
  import apb_slave_pkg::*;

  logic Hclk = 1'b0;
  logic Hresetn = 1'b0;
  int   checks = 0;
  int   passes = 0;
  logic [31:0] exp_regs [0:7];

  apb_slave_regbank_if bus2();
  apb_slave_regbank_if bus0();

  apb_slave_regbank #(.NUM_REGS(8), .WAIT_STATES(2), .ID_VALUE(32'hA5B0_0001)) dut2 (
    .Hclk(Hclk), .Hresetn(Hresetn), .apb(bus2.slave));
  apb_slave_regbank #(.NUM_REGS(8), .WAIT_STATES(0), .ID_VALUE(32'hA5B0_0001)) dut0 (
    .Hclk(Hclk), .Hresetn(Hresetn), .apb(bus0.slave));

  initial forever #5 Hclk = ~Hclk;

  task automatic drv(input bit b0, input bit sel, input bit en, input bit wr,
                     input logic [31:0] addr, input logic [31:0] wdata);
    if (b0) begin
      bus0.Psel = sel; bus0.Penable = en; bus0.Pwrite = wr; bus0.Paddr = addr; bus0.Pwdata = wdata;
    end else begin
      bus2.Psel = sel; bus2.Penable = en; bus2.Pwrite = wr; bus2.Paddr = addr; bus2.Pwdata = wdata;
    end
  endtask

  function automatic logic rdy(input bit b0);
    return b0 ? bus0.Pready : bus2.Pready;
  endfunction

  task automatic idle(input bit b0);
    drv(b0, 1'b0, 1'b0, 1'b0, 32'h0, 32'h0);
  endtask

  // Starts at a falling edge, returns at the falling edge after the completion edge.
  task automatic xfer(input bit b0, input bit wr, input logic [31:0] addr, input logic [31:0] wdata,
                      output logic [31:0] rdata, output logic serr, output int waits, output bit tmo);
    drv(b0, 1'b1, 1'b0, wr, addr, wdata);
    @(negedge Hclk);
    drv(b0, 1'b1, 1'b1, wr, addr, wdata);
    rdata = '0; serr = 1'b0; waits = 0; tmo = 1'b1;
    for (int n = 0; n < 40; n++) begin
      #1;
      if (rdy(b0)) begin
        rdata = b0 ? bus0.Prdata : bus2.Prdata;
        serr  = b0 ? bus0.Pslverr : bus2.Pslverr;
        waits = n;
        tmo   = 1'b0;
        break;
      end
      @(negedge Hclk);
    end
    @(negedge Hclk);
  endtask

  task automatic test_reset;
    idle(1'b0); idle(1'b1);
    Hresetn = 1'b0;
    repeat (3) @(negedge Hclk);
    #1;
    checks++; if ({bus2.Pready, bus2.Pslverr, bus2.Prdata} !== 34'h0)
      $display("FAIL reset_outputs_ws2 got %h want 0", {bus2.Pready, bus2.Pslverr, bus2.Prdata}); else passes++;
    checks++; if ({bus0.Pready, bus0.Pslverr, bus0.Prdata} !== 34'h0)
      $display("FAIL reset_outputs_ws0 got %h want 0", {bus0.Pready, bus0.Pslverr, bus0.Prdata}); else passes++;
    @(negedge Hclk);
    Hresetn = 1'b1;
    for (int i = 0; i < 8; i++) exp_regs[i] = (i == 0) ? 32'hA5B0_0001 : 32'h0;
    @(negedge Hclk);
    for (int i = 1; i < 8; i++) begin
      logic [31:0] rd; logic se; int w; bit t;
      xfer(1'b0, 1'b0, 32'(i * 4), 32'h0, rd, se, w, t);
      idle(1'b0);
      checks++; if (t || rd !== 32'h0 || se !== 1'b0)
        $display("FAIL reset_reg%0d got %h err=%b tmo=%b want 0", i, rd, se, t); else passes++;
    end
  endtask

  task automatic test_write_read;
    logic [31:0] rd; logic se; int w; bit t;
    xfer(1'b0, 1'b1, 32'h4, 32'hA5A5_A5A5, rd, se, w, t);
    #1;
    checks++; if (bus2.Pready !== 1'b0)
      $display("FAIL ready_single_cycle got %b want 0", bus2.Pready); else passes++;
    idle(1'b0);
    exp_regs[1] = 32'hA5A5_A5A5;
    checks++; if (t || w !== 2 || se !== 1'b0)
      $display("FAIL write_latency got waits=%0d err=%b tmo=%b want 2/0/0", w, se, t); else passes++;
    @(negedge Hclk);
    xfer(1'b0, 1'b0, 32'h4, 32'h0, rd, se, w, t);
    idle(1'b0);
    checks++; if (t || w !== 2 || rd !== 32'hA5A5_A5A5 || se !== 1'b0)
      $display("FAIL read_back got %h waits=%0d err=%b want a5a5a5a5/2/0", rd, w, se); else passes++;
  endtask

  task automatic test_id_reg;
    logic [31:0] rd; logic se; int w; bit t;
    xfer(1'b0, 1'b0, 32'h0, 32'h0, rd, se, w, t);
    idle(1'b0);
    checks++; if (t || rd !== 32'hA5B0_0001 || se !== 1'b0)
      $display("FAIL id_read got %h err=%b want a5b00001/0", rd, se); else passes++;
    xfer(1'b0, 1'b1, 32'h0, 32'h1234_5678, rd, se, w, t);
    idle(1'b0);
    checks++; if (t || se !== 1'b1)
      $display("FAIL id_write_err got err=%b tmo=%b want 1", se, t); else passes++;
    xfer(1'b0, 1'b0, 32'h0, 32'h0, rd, se, w, t);
    idle(1'b0);
    checks++; if (t || rd !== 32'hA5B0_0001)
      $display("FAIL id_after_write got %h want a5b00001", rd); else passes++;
  endtask

  task automatic test_errors;
    logic [31:0] rd; logic se; int w; bit t;
    xfer(1'b0, 1'b0, 32'h22, 32'h0, rd, se, w, t);
    idle(1'b0);
    checks++; if (t || se !== 1'b1 || rd !== 32'h0)
      $display("FAIL misaligned_read got %h err=%b want 0/1", rd, se); else passes++;
    xfer(1'b0, 1'b0, 32'h20, 32'h0, rd, se, w, t);
    idle(1'b0);
    checks++; if (t || se !== 1'b1 || rd !== 32'h0)
      $display("FAIL range_read got %h err=%b want 0/1", rd, se); else passes++;
    xfer(1'b0, 1'b1, 32'h22, 32'hFFFF_FFFF, rd, se, w, t);
    idle(1'b0);
    checks++; if (t || se !== 1'b1)
      $display("FAIL misaligned_write_err got %b want 1", se); else passes++;
    xfer(1'b0, 1'b1, 32'h20, 32'hFFFF_FFFF, rd, se, w, t);
    idle(1'b0);
    checks++; if (t || se !== 1'b1)
      $display("FAIL range_write_err got %b want 1", se); else passes++;
    for (int i = 1; i < 8; i++) begin
      xfer(1'b0, 1'b0, 32'(i * 4), 32'h0, rd, se, w, t);
      idle(1'b0);
      checks++; if (t || rd !== exp_regs[i] || se !== 1'b0)
        $display("FAIL unchanged_reg%0d got %h want %h", i, rd, exp_regs[i]); else passes++;
    end
  endtask

  task automatic test_back_to_back;
    logic [31:0] rd1, rd2; logic se1, se2; int w1, w2; bit t1, t2;
    xfer(1'b1, 1'b1, 32'h8, 32'h5A5A_5A5A, rd1, se1, w1, t1);
    xfer(1'b1, 1'b0, 32'h8, 32'h0, rd2, se2, w2, t2);
    idle(1'b1);
    checks++; if (t1 || w1 !== 0 || se1 !== 1'b0)
      $display("FAIL b2b_write got waits=%0d err=%b tmo=%b want 0/0/0", w1, se1, t1); else passes++;
    checks++; if (t2 || w2 !== 0 || rd2 !== 32'h5A5A_5A5A || se2 !== 1'b0)
      $display("FAIL b2b_read got %h waits=%0d err=%b want 5a5a5a5a/0/0", rd2, w2, se2); else passes++;
  endtask

  task automatic test_abort;
    logic [31:0] rd; logic se; int w; bit t; logic seen;
    seen = 1'b0;
    drv(1'b0, 1'b1, 1'b0, 1'b1, 32'hC, 32'hDEAD_BEEF);
    @(negedge Hclk);
    drv(1'b0, 1'b1, 1'b1, 1'b1, 32'hC, 32'hDEAD_BEEF);
    #1 seen = seen | bus2.Pready;
    @(negedge Hclk);
    idle(1'b0);
    #1 seen = seen | bus2.Pready;
    repeat (3) begin
      @(negedge Hclk);
      #1 seen = seen | bus2.Pready;
    end
    checks++; if (seen !== 1'b0)
      $display("FAIL abort_ready got %b want 0", seen); else passes++;
    checks++; if (dut2.state_q !== IDLE)
      $display("FAIL abort_state got %b want IDLE", dut2.state_q); else passes++;
    @(negedge Hclk);
    xfer(1'b0, 1'b0, 32'hC, 32'h0, rd, se, w, t);
    idle(1'b0);
    checks++; if (t || rd !== 32'h0 || se !== 1'b0)
      $display("FAIL abort_no_commit got %h want 0", rd); else passes++;
  endtask

  task automatic test_reset_mid;
    logic [31:0] rd; logic se; int w; bit t;
    xfer(1'b0, 1'b1, 32'h10, 32'h1111_1111, rd, se, w, t);
    idle(1'b0);
    drv(1'b0, 1'b1, 1'b0, 1'b1, 32'h10, 32'h2222_2222);
    @(negedge Hclk);
    drv(1'b0, 1'b1, 1'b1, 1'b1, 32'h10, 32'h2222_2222);
    // bus0 sits in its completion cycle so the asynchronous clear is visible on Pready.
    drv(1'b1, 1'b1, 1'b0, 1'b0, 32'h0, 32'h0);
    @(negedge Hclk);
    drv(1'b1, 1'b1, 1'b1, 1'b0, 32'h0, 32'h0);
    #1;
    checks++; if (bus0.Pready !== 1'b1 || bus0.Prdata !== 32'hA5B0_0001)
      $display("FAIL pre_reset_ready got %b/%h want 1/a5b00001", bus0.Pready, bus0.Prdata); else passes++;
    Hresetn = 1'b0;
    #1;
    checks++; if (bus0.Pready !== 1'b0 || bus0.Prdata !== 32'h0 || bus0.Pslverr !== 1'b0)
      $display("FAIL async_reset_outputs got %b/%h want 0/0", bus0.Pready, bus0.Prdata); else passes++;
    checks++; if (dut2.state_q !== IDLE || bus2.Pready !== 1'b0)
      $display("FAIL async_reset_state got %b want IDLE", dut2.state_q); else passes++;
    idle(1'b0); idle(1'b1);
    repeat (2) @(negedge Hclk);
    Hresetn = 1'b1;
    @(negedge Hclk);
    xfer(1'b0, 1'b0, 32'h10, 32'h0, rd, se, w, t);
    idle(1'b0);
    checks++; if (t || rd !== 32'h0 || se !== 1'b0)
      $display("FAIL reset_clears_reg got %h want 0", rd); else passes++;
  endtask

  initial begin
    test_reset;
    test_write_read;
    test_id_reg;
    test_errors;
    test_back_to_back;
    test_abort;
    test_reset_mid;
    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

endmodule
